// File: rtl/instruction_register_prefetch_queue_pkg.sv
// rtl/instruction_register_prefetch_queue_pkg.sv - shared constants and helpers for the IR prefetch queue
//
// Purpose: default geometry of the instruction register / prefetch queue,
//          the Count width helper and the opcode/operand field-slice helpers.
// Ports:   none (package).
package instruction_register_prefetch_queue_pkg;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_OPCODE_WIDTH = 4;
  localparam int DEFAULT_DEPTH        = 4;

  // Operand always starts at bit 0 of the instruction word.
  localparam int OPERAND_LSB = 0;

  // Count must represent 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int opcodeMsb(input int width);
    return width - 1;
  endfunction

  function automatic int opcodeLsb(input int width, input int opcodeWidth);
    return width - opcodeWidth;
  endfunction

  function automatic int operandMsb(input int width, input int opcodeWidth);
    return width - opcodeWidth - 1;
  endfunction

endpackage

// File: rtl/register_neg_load_enable.sv
// rtl/register_neg_load_enable.sv - falling-edge register with sync active-low clear and active-low load
//
// Purpose: WIDTH-bit storage element used for the instruction register and
//          for every prefetch queue slot.
// Ports:
//   ClkN   in   clock, captures on the falling edge
//   ClrN   in   synchronous active-low clear (wins over LoadN)
//   LoadN  in   active-low load enable; value recirculates when high
//   D      in   WIDTH-bit data to capture
//   Q      out  WIDTH-bit stored value
module register_neg_load_enable #(
  parameter int WIDTH = 8
) (
  input  logic             ClkN,
  input  logic             ClrN,
  input  logic             LoadN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(negedge ClkN) begin
    if (!ClrN) begin
      Q <= '0;
    end else if (!LoadN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/instruction_register_prefetch_queue.sv
// rtl/instruction_register_prefetch_queue.sv - SAP instruction register with a small prefetch queue
//
// Purpose: words pushed from the W bus queue up in DEPTH slots; the controller
//          pops the oldest word into the IR, which exposes opcode/operand fields.
//          Popping an empty queue while pushing bypasses Din straight into the IR.
// Ports:
//   ClkN         in   clock, all state changes on the falling edge
//   ClrN         in   synchronous active-low reset
//   Din          in   WIDTH-bit word from the W bus
//   LoadN        in   active-low push of Din
//   NextN        in   active-low pop of the queue head into the IR
//   Opcode       out  upper OPCODE_WIDTH bits of the IR
//   Operand      out  remaining low bits of the IR
//   IrValid      out  IR holds a word from the latest pop (or not yet superseded)
//   Empty        out  Count == 0
//   Full         out  Count == DEPTH
//   Count        out  occupied queue entries
//   OverflowErr  out  sticky, a push was dropped because the queue was full
module instruction_register_prefetch_queue
  import instruction_register_prefetch_queue_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic                          ClkN,
  input  logic                          ClrN,
  input  logic [WIDTH-1:0]              Din,
  input  logic                          LoadN,
  input  logic                          NextN,
  output logic [OPCODE_WIDTH-1:0]       Opcode,
  output logic [WIDTH-OPCODE_WIDTH-1:0] Operand,
  output logic                          IrValid,
  output logic                          Empty,
  output logic                          Full,
  output logic [countWidth(DEPTH)-1:0]  Count,
  output logic                          OverflowErr
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = countWidth(DEPTH);
  localparam int OP_MSB  = opcodeMsb(WIDTH);
  localparam int OP_LSB  = opcodeLsb(WIDTH, OPCODE_WIDTH);
  localparam int OPR_MSB = operandMsb(WIDTH, OPCODE_WIDTH);

  logic [WIDTH-1:0] entryQ [DEPTH];
  logic [DEPTH-1:0] slotLoadN;
  logic [WIDTH-1:0] irQ;
  logic [WIDTH-1:0] irD;
  logic             irLoadN;

  logic [PTR_W-1:0] wpQ, rpQ;
  logic [CNT_W-1:0] countQ, countD;
  logic             irValidQ;
  logic             overflowQ;

  logic pushReq, popReq, isEmpty, isFull;
  logic bypass, popEn, pushEn, overflowEvt;

  assign pushReq = !LoadN;
  assign popReq  = !NextN;
  assign isEmpty = (countQ == '0);
  assign isFull  = (countQ == CNT_W'(DEPTH));

  // Empty queue with both strobes: Din goes straight to the IR, nothing is stored.
  assign bypass  = pushReq && popReq && isEmpty;
  assign popEn   = popReq && !isEmpty;
  // A pop on the same edge frees the head, so a full queue still accepts the push.
  assign pushEn  = pushReq && !bypass && (!isFull || popEn);
  assign overflowEvt = pushReq && !popReq && isFull;

  assign irLoadN = !(popEn || bypass);
  assign irD     = bypass ? Din : entryQ[rpQ];

  always_comb begin
    countD = countQ;
    if (pushEn && !popEn) begin
      countD = countQ + CNT_W'(1);
    end else if (popEn && !pushEn) begin
      countD = countQ - CNT_W'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : gSlot
      assign slotLoadN[i] = !(pushEn && (wpQ == PTR_W'(i)));

      register_neg_load_enable #(
        .WIDTH(WIDTH)
      ) uSlot (
        .ClkN (ClkN),
        .ClrN (ClrN),
        .LoadN(slotLoadN[i]),
        .D    (Din),
        .Q    (entryQ[i])
      );
    end
  endgenerate

  register_neg_load_enable #(
    .WIDTH(WIDTH)
  ) uIr (
    .ClkN (ClkN),
    .ClrN (ClrN),
    .LoadN(irLoadN),
    .D    (irD),
    .Q    (irQ)
  );

  always_ff @(negedge ClkN) begin
    if (!ClrN) begin
      wpQ       <= '0;
      rpQ       <= '0;
      countQ    <= '0;
      irValidQ  <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      if (pushEn) begin
        wpQ <= wpQ + PTR_W'(1);
      end
      if (popEn) begin
        rpQ <= rpQ + PTR_W'(1);
      end
      countQ <= countD;
      // A pop request on an empty queue without a bypass word invalidates the IR.
      if (popReq) begin
        irValidQ <= popEn || bypass;
      end
      if (overflowEvt) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign Opcode      = irQ[OP_MSB:OP_LSB];
  assign Operand     = irQ[OPR_MSB:OPERAND_LSB];
  assign IrValid     = irValidQ;
  assign Empty       = isEmpty;
  assign Full        = isFull;
  assign Count       = countQ;
  assign OverflowErr = overflowQ;

endmodule

// File: tb/tb_instruction_register_prefetch_queue.sv
// tb/tb_instruction_register_prefetch_queue.sv - self-checking bench for the IR prefetch queue
module tb_instruction_register_prefetch_queue;

  localparam int DEPTH = 4;

  logic       ClkN;
  logic       ClrN;
  logic [7:0] Din;
  logic       LoadN;
  logic       NextN;
  logic [3:0] Opcode;
  logic [3:0] Operand;
  logic       IrValid;
  logic       Empty;
  logic       Full;
  logic [2:0] Count;
  logic       OverflowErr;

  instruction_register_prefetch_queue #(
    .WIDTH(8),
    .OPCODE_WIDTH(4),
    .DEPTH(DEPTH)
  ) dut (
    .ClkN       (ClkN),
    .ClrN       (ClrN),
    .Din        (Din),
    .LoadN      (LoadN),
    .NextN      (NextN),
    .Opcode     (Opcode),
    .Operand    (Operand),
    .IrValid    (IrValid),
    .Empty      (Empty),
    .Full       (Full),
    .Count      (Count),
    .OverflowErr(OverflowErr)
  );

  initial ClkN = 1'b1;
  always #5 ClkN = ~ClkN;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue plus the IR contents and flags.
  logic [7:0] mq[$];
  logic [7:0] mIr = 8'h00;
  bit         mValid = 0;
  bit         mOvf = 0;
  bit         compareOn = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate(input logic clr, input logic ld, input logic nx, input logic [7:0] d);
    if (!clr) begin
      mq.delete();
      mIr = 8'h00;
      mValid = 0;
      mOvf = 0;
    end else if (!nx) begin
      if (mq.size() > 0) begin
        mIr = mq.pop_front();
        mValid = 1;
        if (!ld) mq.push_back(d);
      end else if (!ld) begin
        mIr = d;
        mValid = 1;
      end else begin
        mValid = 0;
      end
    end else if (!ld) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else mOvf = 1;
    end
  endtask

  // Inputs change on the rising edge; the DUT and model update on the falling edge.
  task automatic step(input logic clr, input logic ld, input logic nx, input logic [7:0] d);
    ClrN = clr; LoadN = ld; NextN = nx; Din = d;
    @(negedge ClkN);
    modelUpdate(clr, ld, nx, d);
    @(posedge ClkN);
  endtask

  task automatic push(input logic [7:0] d); step(1, 0, 1, d); endtask
  task automatic pop();                     step(1, 1, 0, 8'h00); endtask
  task automatic idle();                    step(1, 1, 1, 8'h00); endtask

  always @(posedge ClkN) begin
    if (compareOn) begin
      chk("opcode",   int'(Opcode),      int'(mIr[7:4]));
      chk("operand",  int'(Operand),     int'(mIr[3:0]));
      chk("irvalid",  int'(IrValid),     int'(mValid));
      chk("empty",    int'(Empty),       int'(mq.size() == 0));
      chk("full",     int'(Full),        int'(mq.size() == DEPTH));
      chk("count",    int'(Count),       mq.size());
      chk("overflow", int'(OverflowErr), int'(mOvf));
    end
  end

  logic [7:0] ir;
  assign ir = {Opcode, Operand};

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h1A; fill[1] = 8'h2B; fill[2] = 8'h3C; fill[3] = 8'h4D;
    ClrN = 0; LoadN = 1; NextN = 1; Din = 8'h00;

    // Reset, then random traffic, then reset again.
    step(0, 1, 1, 8'h00);
    compareOn = 1;
    for (int k = 0; k < 8; k++) step(1, 1'($urandom), 1'($urandom), 8'($urandom));
    step(0, 1'($urandom), 1'($urandom), 8'($urandom));
    chk("rst_ir", int'(ir), 0);
    chk("rst_empty", int'(Empty), 1);
    chk("rst_count", int'(Count), 0);
    chk("rst_valid", int'(IrValid), 0);
    idle();
    chk("rst_hold_ir", int'(ir), 0);
    chk("rst_hold_ovf", int'(OverflowErr), 0);

    // Fill and drain.
    for (int k = 0; k < 4; k++) push(fill[k]);
    chk("fill_full", int'(Full), 1);
    chk("fill_count", int'(Count), 4);
    for (int k = 0; k < 4; k++) begin
      pop();
      chk("drain_ir", int'(ir), int'(fill[k]));
    end
    chk("drain_empty", int'(Empty), 1);
    pop();
    chk("pop_empty_valid", int'(IrValid), 0);
    chk("pop_empty_ir", int'(ir), 8'h4D);

    // Overflow: dropped word never emerges.
    for (int k = 0; k < 4; k++) push(fill[k]);
    push(8'h5E);
    chk("ovf_count", int'(Count), 4);
    chk("ovf_flag", int'(OverflowErr), 1);
    for (int k = 0; k < 4; k++) begin
      pop();
      chk("ovf_drain_ir", int'(ir), int'(fill[k]));
    end
    pop();
    chk("ovf_no_5e", int'(ir != 8'h5E), 1);

    // Bypass on an empty queue.
    step(1, 0, 0, 8'h6F);
    chk("bypass_ir", int'(ir), 8'h6F);
    chk("bypass_count", int'(Count), 0);
    chk("bypass_valid", int'(IrValid), 1);

    // Full push+pop: no overflow change, new word comes out last.
    step(0, 1, 1, 8'h00);
    for (int k = 0; k < 4; k++) push(fill[k]);
    step(1, 0, 0, 8'h70);
    chk("fullpp_ir", int'(ir), 8'h1A);
    chk("fullpp_count", int'(Count), 4);
    chk("fullpp_ovf", int'(OverflowErr), 0);
    for (int k = 1; k < 4; k++) begin
      pop();
      chk("fullpp_drain", int'(ir), int'(fill[k]));
    end
    pop();
    chk("fullpp_last", int'(ir), 8'h70);

    // Hold and pointer wrap with idle edges.
    for (int k = 0; k < 10; k++) begin
      logic [7:0] w;
      w = 8'($urandom);
      push(w);
      idle();
      pop();
      idle();
      idle();
      chk("wrap_hold_ir", int'(ir), int'(w));
    end

    // Reset mid-stream with two queued words.
    push(8'hA1);
    push(8'hB2);
    chk("mid_count", int'(Count), 2);
    step(0, 1, 1, 8'h00);
    chk("mid_empty", int'(Empty), 1);
    pop();
    chk("mid_pop_valid", int'(IrValid), 0);

    // Randomized traffic checked every cycle by the compare process.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           1'($urandom), 8'($urandom));
    end

    compareOn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_register_prefetch_queue.md
Name: instruction_register_prefetch_queue

Overview:
- Parametrised SAP-family instruction register with a small prefetch queue in front of it.
- Words are pushed from the W bus under an active-low load strobe.
- The controller pops the oldest word into the instruction register (IR) under an active-low advance strobe.
- The IR exposes opcode and operand fields, and holds its value indefinitely when not advanced.

Parameters:
- WIDTH, 8, instruction word width in bits (≥2).
- OPCODE_WIDTH, 4, upper bits of the word that form the opcode (1..WIDTH-1).
- DEPTH, 4, queue entries (power of two, ≥2).

Ports:
- ClkN  in  1  clock; all state updates on the falling edge.
- ClrN  in  1  reset; synchronous, active-low, sampled on the ClkN falling edge.
- Din  in  WIDTH  word from the W bus.
- LoadN  in  1  active-low push of Din into the queue.
- NextN  in  1  active-low pop of the queue head into the IR.
- Opcode  out  OPCODE_WIDTH  IR[WIDTH-1 -: OPCODE_WIDTH].
- Operand  out  WIDTH-OPCODE_WIDTH  IR[WIDTH-OPCODE_WIDTH-1:0].
- IrValid  out  1  IR holds a word popped by the most recent NextN edge, or a word not yet superseded.
- Empty  out  1  Count==0.
- Full  out  1  Count==DEPTH.
- Count  out  $clog2(DEPTH)+1  occupied entries.
- OverflowErr  out  1  sticky; a push was dropped.

Behaviour:
- Reset (ClrN low at a falling edge):
  - IR, all entries, read/write pointers, Count, IrValid and OverflowErr go to 0.
  - Reset overrides LoadN and NextN.
  - Reset asserted mid-stream discards queued words.
- Hold: with LoadN=1 and NextN=1, every register recirculates its value (per-slot mux on load enable). No output changes.
- Push only (LoadN=0, NextN=1):
  - Not full: entry[wp] <= Din; wp <= wp+1 mod DEPTH; Count+1.
  - Full: Din is dropped, state is unchanged, OverflowErr <= 1.
- Pop only (LoadN=1, NextN=0):
  - Not empty: IR <= entry[rp]; rp+1 mod DEPTH; Count-1; IrValid <= 1.
  - Empty: IR holds, IrValid <= 0.
- Push and pop in the same edge:
  - Empty (bypass): IR <= Din; IrValid <= 1; Count stays 0.
  - Otherwise: pop the head into the IR and push Din into the queue. Both pointers advance; Count is unchanged, including when Full (no overflow).
- Outputs:
  - All outputs are registered or decoded from registers; none is combinational from Din, LoadN or NextN.
  - Empty, Full and Count reflect post-edge state.
- Latency:
  - A word pushed at edge k can reach the IR at edge k+1 at the earliest; bypass is edge k.
  - Opcode and Operand are valid after the edge that loaded the IR.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and Empty are derived from Count only.
- OverflowErr clears only on reset.

Decomposition:
- Shared package:
  - Default WIDTH, OPCODE_WIDTH and DEPTH constants.
  - Function for the Count width.
  - Field-slice localparams (opcode MSB/LSB, operand MSB/LSB) reused by the controller.
- One natural sub-module: register_neg_load_enable (WIDTH).
  - WIDTH-bit falling-edge register with synchronous active-low reset and active-low load enable.
  - Holds its value when the enable is high.
  - Instantiated for the IR and for each queue slot.

Test Plan:
- Reset: drive random values, then ClrN=0 for one edge → all outputs 0, Empty=1, Count=0; ClrN=1 with no strobes → outputs stay 0.
- Fill and drain (WIDTH=8, OPCODE_WIDTH=4, DEPTH=4):
  - Push 0x1A, 0x2B, 0x3C, 0x4D → Full=1, Count=4.
  - Four pops → Opcode/Operand = 1/A, 2/B, 3/C, 4/D on consecutive edges; Empty=1.
  - A fifth pop → IrValid=0 and IR still 0x4D.
- Overflow: with the queue full, push 0x5E alone → Count=4, OverflowErr=1. A later drain yields 0x1A..0x4D only, never 0x5E.
- Simultaneous operations:
  - Empty, push 0x6F with pop → IR=0x6F, Count=0, IrValid=1.
  - Full, push 0x70 with pop → IR=old head, Count=4, OverflowErr unchanged, 0x70 emerges last.
- Hold and wrap: push/pop 10 words with idle cycles between → IR is stable across idle edges, FIFO order is preserved across pointer wrap. Reset mid-stream with Count=2 → Empty=1, next pop gives IrValid=0.
